// File: rtl/huff_sample_writer.sv
// Writes decoded Huffman (x, y) pairs as consecutive signed samples into the granule
// sample memory through a small pair FIFO, then zero-fills the granule and pulses done.
module huff_sample_writer #(
    parameter int unsigned NUM_SAMPLES = 576,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [8:0]        big_values,
    input  logic              axiov,
    input  logic [DATA_W-1:0] x_val,
    input  logic [DATA_W-1:0] y_val,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_extra
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [8:0] MaxPairs = 9'(NUM_SAMPLES / 2);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {StIdle, StPairs, StZeroFill, StDone} state_e;

    state_e                               state_q, state_d;
    logic [8:0]                           bv_q, bv_d, bv_clamped;
    logic [8:0]                           rx_cnt_q, rx_cnt_d;
    logic [ADDR_W-1:0]                    wr_idx_q, wr_idx_d, pair_end;
    logic                                 half_q, half_d;
    logic [FIFO_DEPTH-1:0][2*DATA_W-1:0]  fifo_q, fifo_d;
    logic [PtrW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                      count_q, count_d;
    logic [2*DATA_W-1:0]                  head_d;
    logic                                 err_overflow_q, err_overflow_d;
    logic                                 err_extra_q, err_extra_d;
    logic                                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]                    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]                    wr_data_q, wr_data_d;
    logic                                 busy_q, done_q;
    logic                                 full, accept, push, pop, pair_vld_d;

    assign full       = (count_q == CntW'(FIFO_DEPTH));
    assign in_ready   = ~full;
    assign accept     = wr_en_q & wr_ready;
    assign push       = (state_q == StPairs) & axiov & (rx_cnt_q < bv_q) & ~full;
    assign pop        = (state_q == StPairs) & accept & half_q;
    assign bv_clamped = (big_values > MaxPairs) ? MaxPairs : big_values;
    assign pair_end   = ADDR_W'({bv_q, 1'b0});

    always_comb begin
        state_d        = state_q;
        bv_d           = bv_q;
        rx_cnt_d       = rx_cnt_q;
        wr_idx_d       = wr_idx_q;
        half_d         = half_q;
        fifo_d         = fifo_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        err_overflow_d = err_overflow_q;
        err_extra_d    = err_extra_q;

        if (push) begin
            fifo_d[wr_ptr_q] = {x_val, y_val};
            wr_ptr_d         = wr_ptr_q + 1'b1;
            rx_cnt_d         = rx_cnt_q + 9'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bv_d           = bv_clamped;
                    rx_cnt_d       = '0;
                    wr_idx_d       = '0;
                    half_d         = 1'b0;
                    err_overflow_d = 1'b0;
                    err_extra_d    = 1'b0;
                    state_d        = (bv_clamped == '0) ? StZeroFill : StPairs;
                end
            end
            StPairs: begin
                if (accept) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    half_d   = ~half_q;
                    // A full-granule pair load has nothing left to zero-fill.
                    if (half_q && (wr_idx_q == pair_end - 1'b1)) begin
                        state_d = (bv_q == MaxPairs) ? StDone : StZeroFill;
                    end
                end
            end
            StZeroFill: begin
                if (accept) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Applied after the start clear so a strobe in that cycle is still flagged.
        if (axiov && full) begin
            err_overflow_d = 1'b1;
        end
        if (axiov && ((state_q != StPairs) || (rx_cnt_q == bv_q))) begin
            err_extra_d = 1'b1;
        end

        // Write port registers hold the sample selected by the next-cycle state.
        head_d     = fifo_d[rd_ptr_d];
        pair_vld_d = (state_d == StPairs) && (count_d != '0);
        wr_en_d    = pair_vld_d || (state_d == StZeroFill);
        wr_addr_d  = wr_en_d ? wr_idx_d : '0;
        if (pair_vld_d) begin
            wr_data_d = half_d ? head_d[DATA_W-1:0] : head_d[2*DATA_W-1:DATA_W];
        end else begin
            wr_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            bv_q           <= '0;
            rx_cnt_q       <= '0;
            wr_idx_q       <= '0;
            half_q         <= 1'b0;
            fifo_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            err_overflow_q <= 1'b0;
            err_extra_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bv_q           <= bv_d;
            rx_cnt_q       <= rx_cnt_d;
            wr_idx_q       <= wr_idx_d;
            half_q         <= half_d;
            fifo_q         <= fifo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            err_overflow_q <= err_overflow_d;
            err_extra_q    <= err_extra_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            busy_q         <= (state_d != StIdle);
            done_q         <= (state_d == StDone);
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_overflow_q;
    assign err_extra    = err_extra_q;

endmodule

// File: doc/huff_sample_writer.md
Name: huff_sample_writer

Overview:
- Sits directly downstream of the per-table Huffman pair decoders.
- Takes each decoded (x_val, y_val) pair on a one-cycle axiov strobe and writes it as two consecutive signed samples into the 576-entry granule sample memory.
- Once big_values pairs are written, zero-fills the rest of the granule and pulses done.
- Absorbs memory backpressure through a small pair FIFO and tells the bit feeder when to stall.

Parameters:
- NUM_SAMPLES, 576, samples per granule channel.
- ADDR_W, 10, sample memory address width.
- DATA_W, 16, sample width (matches decoder x_val/y_val).
- FIFO_DEPTH, 2, pair FIFO depth in pairs (power of two).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a granule; ignored unless IDLE.
- big_values  input  9  number of pairs to expect; sampled on start.
- axiov  input  1  decoder pair-valid strobe, one cycle per pair.
- x_val  input  DATA_W  signed first sample of pair.
- y_val  input  DATA_W  signed second sample of pair.
- in_ready  output  1  high when FIFO has room; feeder must hold axiid/axiiv low while low.
- wr_en  output  1  sample write request.
- wr_addr  output  ADDR_W  sample index.
- wr_data  output  DATA_W  signed sample.
- wr_ready  input  1  memory accepts on wr_en && wr_ready.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when the last sample (index NUM_SAMPLES-1) is accepted.
- err_overflow  output  1  sticky: pair strobed while FIFO full.
- err_extra  output  1  sticky: pair strobed outside PAIRS or after big_values pairs already received.

Behaviour:
- Reset (rst_n low, async): state IDLE, FIFO empty, all counters 0, all outputs 0 except in_ready=1.
- Clamp on start: bv = min(big_values, NUM_SAMPLES/2 = 288).
- Counters: rx_cnt (pairs pushed), wr_idx (next sample index, 0..575), half (0 = x, 1 = y).
- State IDLE:
  - start -> PAIRS if bv > 0, else ZERO_FILL.
  - Latch bv and clear rx_cnt, wr_idx, half.
- State PAIRS:
  - Push: when axiov && rx_cnt < bv && FIFO not full, push {x_val, y_val} and increment rx_cnt.
  - Pop side: wr_en=1 whenever the FIFO is non-empty.
  - wr_data = head.x when half=0, head.y when half=1; wr_addr = wr_idx.
  - On accept: wr_idx++ and half toggles; when half was 1, pop the head.
  - Exit to ZERO_FILL when the y of pair bv is accepted (wr_idx becomes 2*bv).
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- State ZERO_FILL:
  - wr_en=1, wr_data=0, wr_addr=wr_idx; wr_idx++ on accept.
  - When index NUM_SAMPLES-1 is accepted -> DONE.
  - If bv=288, PAIRS ends at wr_idx=576: skip ZERO_FILL, go straight to DONE, and pulse done on that final accept.
- State DONE: done=1 for exactly this one cycle, wr_en=0, -> IDLE.
- Write outputs:
  - wr_en, wr_addr and wr_data are registered.
  - They must stay stable while wr_en && !wr_ready.
  - Throughput is one sample per cycle with wr_ready held high.
- Latency: a pair strobed at cycle t gives x on the write port at t+1 and y at t+2 (FIFO empty, wr_ready=1).
- in_ready = !FIFO full, combinational from occupancy.
- Errors:
  - Strobe with FIFO full: the pair is dropped and err_overflow is set.
  - Strobe in IDLE, ZERO_FILL or DONE, or with rx_cnt == bv: the pair is dropped and err_extra is set.
  - Both flags clear only on reset or on start.
- Signed values pass through unmodified; no saturation.
- start while busy: ignored; no state or flag change.
- Reset mid-granule: everything aborts immediately to reset values and the FIFO contents are discarded.

Test Plan:
- bv=3; pairs (1,-1), (15+31=46,0), (-2,5) spaced 4 cycles apart; wr_ready=1 -> writes idx0..5 = 1, -1, 46, 0, -2, 5; idx6..575 = 0; done pulses once, one cycle after the idx575 accept; no error flags.
- bv=0, start -> 576 zero writes at idx 0..575 on consecutive cycles, then done; busy low afterwards.
- bv=2, wr_ready held low for 20 cycles while pairs (3,4), (5,6) arrive -> in_ready drops after the second push; the write port holds idx0=3 stable; after release, writes 3, 4, 5, 6 then zeros; err_overflow=0.
- Same stall, but a third strobe arrives while in_ready=0 -> err_overflow=1 and that pair does not appear in memory.
- bv=1, two strobes (7,8) then (9,9) -> only idx0=7, idx1=8 written, err_extra=1; big_values=400 -> clamped to 288, no zero fill, done when idx575 is accepted.
- Assert rst_n low mid-ZERO_FILL at wr_idx=300 -> outputs clear asynchronously, wr_en=0 and done never pulses; a subsequent start runs a full granule correctly.
